// File: rtl/keypad_scan_ctrl_if.sv
// rtl/keypad_scan_ctrl_if.sv - keypad pins and key event/display signals
interface keypad_scan_ctrl_if;
  logic [3:0] c;
  logic [3:0] r;
  logic       key_valid;
  logic [3:0] key_code;
  logic [3:0] digit_new;
  logic [3:0] digit_old;

  // controller side
  modport slave (input c, output r, key_valid, key_code, digit_new, digit_old);
  // keypad / consumer side
  modport master (output c, input r, key_valid, key_code, digit_new, digit_old);
endinterface

// File: rtl/keypad_scan_ctrl.sv
// rtl/keypad_scan_ctrl.sv - 4x4 keypad scanner/debouncer, optional KEYPAD_SCAN_AUTOREPEAT_EN
module keypad_scan_ctrl #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEB_TICKS    = 20,
  parameter int REPEAT_TICKS = 500
) (
  input  logic               clk,
  input  logic               resetInv,
  keypad_scan_ctrl_if.slave  bus
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = $clog2(DEB_TICKS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_TICKS);

  localparam logic [1:0] S_SCAN    = 2'd0;
  localparam logic [1:0] S_DEBOUNCE = 2'd1;
  localparam logic [1:0] S_HELD    = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  logic [3:0]    c_s1, cs;
  logic [CW-1:0] cnt;
  logic          tick;
  logic [1:0]    state;
  logic [1:0]    row, col, low_col;
  logic [DW-1:0] deb, deb_nxt;
  logic          col_high;
  logic          kv;
  logic [3:0]    code, dnew, dold;

  // hex value printed on the key at a given row/column
  function automatic logic [3:0] keymap(input logic [1:0] rw, input logic [1:0] cl);
    case ({rw, cl})
      4'h0: keymap = 4'h1;  4'h1: keymap = 4'h2;  4'h2: keymap = 4'h3;  4'h3: keymap = 4'hA;
      4'h4: keymap = 4'h4;  4'h5: keymap = 4'h5;  4'h6: keymap = 4'h6;  4'h7: keymap = 4'hB;
      4'h8: keymap = 4'h7;  4'h9: keymap = 4'h8;  4'hA: keymap = 4'h9;  4'hB: keymap = 4'hC;
      4'hC: keymap = 4'hE;  4'hD: keymap = 4'h0;  4'hE: keymap = 4'hF;  default: keymap = 4'hD;
    endcase
  endfunction

  // two-flop synchronizer on the raw columns; idle level is all-high
  always_ff @(posedge clk or negedge resetInv) begin
    if (!resetInv) begin
      c_s1 <= 4'hF;
      cs   <= 4'hF;
    end else begin
      c_s1 <= bus.c;
      cs   <= c_s1;
    end
  end

  // scan tick divider
  always_ff @(posedge clk or negedge resetInv) begin
    if (!resetInv) cnt <= '0;
    else           cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
  end

  assign tick     = (cnt == CNT_LAST);
  assign col_high = cs[col];
  assign deb_nxt  = (deb == DEB_LAST) ? deb : deb + 1'b1;

  // lowest-index pulled-low column wins when several are low
  always_comb begin
    low_col = 2'd3;
    if      (!cs[0]) low_col = 2'd0;
    else if (!cs[1]) low_col = 2'd1;
    else if (!cs[2]) low_col = 2'd2;
  end

`ifdef KEYPAD_SCAN_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_TICKS + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_TICKS);
  logic [RW-1:0] rep;
`endif

  // scan/debounce sequencer; every transition waits for a tick
  always_ff @(posedge clk or negedge resetInv) begin
    if (!resetInv) begin
      state <= S_SCAN;
      row   <= 2'd0;
      col   <= 2'd0;
      deb   <= '0;
      kv    <= 1'b0;
      code  <= 4'h0;
      dnew  <= 4'h0;
      dold  <= 4'h0;
`ifdef KEYPAD_SCAN_AUTOREPEAT_EN
      rep   <= '0;
`endif
    end else begin
      kv <= 1'b0;
      if (tick) begin
        case (state)
          S_SCAN: begin
            if (cs == 4'hF) begin
              row <= row + 1'b1;
            end else begin
              col <= low_col;
              if (DEB_TICKS == 1) begin
                kv    <= 1'b1;
                code  <= keymap(row, low_col);
                dnew  <= keymap(row, low_col);
                dold  <= dnew;
                state <= S_HELD;
              end else begin
                deb   <= DW'(1);
                state <= S_DEBOUNCE;
              end
            end
          end
          S_DEBOUNCE: begin
            if (!col_high) begin
              deb <= deb_nxt;
              if (deb_nxt == DEB_LAST) begin
                kv    <= 1'b1;
                code  <= keymap(row, col);
                dnew  <= keymap(row, col);
                dold  <= dnew;
                state <= S_HELD;
              end
            end else begin
              row   <= row + 1'b1;
              state <= S_SCAN;
            end
          end
          S_HELD: begin
            if (col_high) begin
`ifdef KEYPAD_SCAN_AUTOREPEAT_EN
              rep <= '0;
`endif
              if (DEB_TICKS == 1) begin
                row   <= row + 1'b1;
                state <= S_SCAN;
              end else begin
                deb   <= DW'(1);
                state <= S_RELEASE;
              end
            end else begin
`ifdef KEYPAD_SCAN_AUTOREPEAT_EN
              if (rep + 1'b1 == REP_LAST) begin
                rep  <= '0;
                kv   <= 1'b1;
                dnew <= code;
                dold <= dnew;
              end else begin
                rep <= rep + 1'b1;
              end
`endif
            end
          end
          default: begin
            if (col_high) begin
              deb <= deb_nxt;
              if (deb_nxt == DEB_LAST) begin
                row   <= row + 1'b1;
                state <= S_SCAN;
              end
            end else begin
              state <= S_HELD;
            end
          end
        endcase
      end
    end
  end

  assign bus.r         = ~(4'b0001 << row);
  assign bus.key_valid = kv;
  assign bus.key_code  = code;
  assign bus.digit_new = dnew;
  assign bus.digit_old = dold;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb/tb_keypad_scan_ctrl.sv - randomized bench with keypad model and reference scoreboard
module tb_keypad_scan_ctrl;
  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;
  localparam int REP      = 5;

  logic clk = 1'b0;
  logic resetInv = 1'b0;
  logic [15:0] key_down = '0;
  logic [3:0]  kp_c;

  keypad_scan_ctrl_if kp ();

  keypad_scan_ctrl #(.SCAN_DIV(SCAN_DIV), .DEB_TICKS(DEB), .REPEAT_TICKS(REP)) dut (
    .clk(clk), .resetInv(resetInv), .bus(kp)
  );

  always #5 clk = ~clk;

  // physical keypad: a held key shorts its column to its row line
  always_comb begin
    kp_c = 4'hF;
    for (int i = 0; i < 16; i++)
      if (key_down[i] && !kp.r[i / 4]) kp_c[i % 4] = 1'b0;
  end
  assign kp.c = kp_c;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference: key table, row-major, column 0 first
  int keytab [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

  // model variables: scan position, tracked key and agreement streaks
  int m_cnt, m_row, m_col, streak, rep, m_pulses;
  logic [3:0] m_s1, m_cs;
  bit trk, acc, rel;
  bit e_kv;
  int e_code, e_new, e_old;

  task automatic model_reset();
    m_cnt = 0; m_row = 0; m_col = 0; streak = 0; rep = 0;
    m_s1 = 4'hF; m_cs = 4'hF;
    trk = 0; acc = 0; rel = 0;
    e_kv = 0; e_code = 0; e_new = 0; e_old = 0;
  endtask

  task automatic emit(input int code);
    e_kv = 1; e_code = code; e_old = e_new; e_new = code; m_pulses++;
  endtask

  task automatic model_step();
    logic [3:0] cs_now;
    bit tick, low;
    cs_now = m_cs;
    tick = (m_cnt == SCAN_DIV - 1);
    m_cnt = tick ? 0 : m_cnt + 1;
    m_cs = m_s1;
    m_s1 = kp.c;
    e_kv = 0;
    if (!tick) return;
    if (!trk) begin
      if (cs_now == 4'hF) m_row = (m_row + 1) % 4;
      else begin
        m_col = 3;
        for (int i = 3; i >= 0; i--) if (!cs_now[i]) m_col = i;
        trk = 1; acc = 0; rel = 0; streak = 1;
        if (streak >= DEB) begin acc = 1; rep = 0; emit(keytab[m_row * 4 + m_col]); end
      end
    end else begin
      low = !cs_now[m_col];
      if (!acc) begin
        if (low) begin
          streak++;
          if (streak >= DEB) begin acc = 1; rep = 0; emit(keytab[m_row * 4 + m_col]); end
        end else begin
          trk = 0; m_row = (m_row + 1) % 4;
        end
      end else if (!rel) begin
        if (low) begin
`ifdef KEYPAD_SCAN_AUTOREPEAT_EN
          rep++;
          if (rep == REP) begin rep = 0; emit(e_code); end
`endif
        end else begin
          rep = 0; rel = 1; streak = 1;
          if (streak >= DEB) begin trk = 0; m_row = (m_row + 1) % 4; end
        end
      end else begin
        if (low) rel = 0;
        else begin
          streak++;
          if (streak >= DEB) begin trk = 0; m_row = (m_row + 1) % 4; end
        end
      end
    end
  endtask

  initial begin
    m_pulses = 0;
    model_reset();
    forever begin
      @(posedge clk or negedge resetInv);
      if (!resetInv) model_reset();
      else model_step();
    end
  end

  // per-cycle scoreboard and pulse log, sampled on the falling edge
  int cyc = 0;
  int pulses = 0;
  int pulse_cyc [$];
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (kp.key_valid === 1'b1) begin pulses++; pulse_cyc.push_back(cyc); end
      check("outs", {15'd0, kp.r, kp.key_valid, kp.key_code, kp.digit_new, kp.digit_old},
            {15'd0, ~(4'b0001 << m_row), e_kv, 4'(e_code), 4'(e_new), 4'(e_old)});
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_outs(input string tag);
    check(tag, {15'd0, kp.r, kp.key_valid, kp.key_code, kp.digit_new, kp.digit_old},
          {15'd0, 4'b1110, 1'b0, 12'h000});
  endtask

  logic [3:0] rseq [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
  int p0, n, hold;

  initial begin
    // reset state and free scan rotation
    cycles(2);
    check_reset_outs("reset");
    resetInv = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycles(4);
      check("rseq", {28'd0, kp.r}, {28'd0, rseq[k]});
    end

    // hold "5" for 200 cycles
    p0 = pulses;
    key_down[5] = 1'b1;
    cycles(200);
    check("hold5_r", {28'd0, kp.r}, 32'hD);
    check("hold5_code", {28'd0, kp.key_code}, 32'h5);
    check("hold5_new", {28'd0, kp.digit_new}, 32'h5);
`ifndef KEYPAD_SCAN_AUTOREPEAT_EN
    check("hold5_old", {28'd0, kp.digit_old}, 32'h0);
    check("hold5_pulses", pulses - p0, 1);
`endif
    key_down = '0;
    cycles(40);

    // "9" then "D"
    p0 = pulses;
    key_down[10] = 1'b1; cycles(60); key_down = '0; cycles(40);
    key_down[15] = 1'b1; cycles(60);
    check("d9_new", {28'd0, kp.digit_new}, 32'hD);
`ifndef KEYPAD_SCAN_AUTOREPEAT_EN
    check("d9_old", {28'd0, kp.digit_old}, 32'h9);
    check("d9_pulses", pulses - p0, 2);
`endif
    key_down = '0;
    cycles(40);

    // bounce: each press lasts exactly one tick period
    p0 = pulses;
    for (int k = 0; k < 5; k++) begin
      key_down[$urandom_range(0, 15)] = 1'b1;
      cycles(SCAN_DIV);
      key_down = '0;
      cycles(3 * SCAN_DIV);
    end
    check("bounce_pulses", pulses - p0, 0);

    // release glitch while held
    p0 = pulses;
    key_down[0] = 1'b1; cycles(60);
    key_down = '0; cycles(SCAN_DIV);
    key_down[0] = 1'b1; cycles(40);
`ifndef KEYPAD_SCAN_AUTOREPEAT_EN
    check("glitch_pulses", pulses - p0, 1);
`endif
    check("glitch_r", {28'd0, kp.r}, 32'hE);
    key_down = '0;
    cycles(40);

    // reset in the middle of debouncing "E"
    key_down[12] = 1'b1;
    n = 0;
    while (!(trk && !acc) && n < 100) begin @(negedge clk); n++; end
    check("deb_reach", n < 100, 1);
    #1 resetInv = 1'b0;
    #1 check_reset_outs("mid_reset");
    key_down = '0;
    cycles(3);
    resetInv = 1'b1;
    cycles(20);

`ifdef KEYPAD_SCAN_AUTOREPEAT_EN
    // auto-repeat of "A": pulses spaced REP ticks apart
    p0 = pulse_cyc.size();
    key_down[3] = 1'b1;
    cycles(120);
    key_down = '0;
    check("rep_count", pulse_cyc.size() - p0 >= 3, 1);
    for (int k = p0 + 1; k < pulse_cyc.size(); k++)
      check("rep_gap", pulse_cyc[k] - pulse_cyc[k - 1], REP * SCAN_DIV);
    check("rep_code", {28'd0, kp.key_code}, 32'hA);
    cycles(40);
`endif

    // random presses, multi-key presses and release glitches
    for (int it = 0; it < 30; it++) begin
      key_down[$urandom_range(0, 15)] = 1'b1;
      if ($urandom_range(0, 3) == 0) key_down[$urandom_range(0, 15)] = 1'b1;
      hold = $urandom_range(1, 80);
      cycles(hold);
      if ($urandom_range(0, 2) == 0) begin
        logic [15:0] keep;
        keep = key_down;
        key_down = '0;
        cycles($urandom_range(1, 6));
        key_down = keep;
        cycles($urandom_range(1, 40));
      end
      key_down = '0;
      cycles($urandom_range(1, 60));
    end
    cycles(40);
    check("pulse_total", pulses, m_pulses);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
